gps_round_sched: RTL and testbench
==================================

# gps_round_sched

Round scheduler for the GPS code generator. It steps the satellite-vehicle number across a programmed range and drives the generator's start-round request. It waits for the code-valid rising edge, with a timeout, and hands each captured C/A code to a downstream consumer over a valid/ready port. It sits between the generator and the Wishbone register front end, so the generator scans satellites autonomously instead of one software write per round.

## Interface
- SV_FIRST, 1: first sv_num of the scan (1..63)
- SV_LAST, 32: last sv_num of the scan (≥ SV_FIRST, ≤ 63)
- TIMEOUT, 4096: cycles allowed in REQ before a round is abandoned (≥ 2)

- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  one clock; reset is asynchronous and active-low
- enable_i  in  1  scan enable, level
- start_o  out  1  to generator startRound
- sv_num_o  out  6  to generator sv_num
- codes_valid_i  in  1  generator code-valid, already synchronous to wb_clk_i
- ca_code_i  in  13  generator C/A code
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer accepts result
- res_sv_o  out  6  sv_num of the result
- res_code_o  out  13  captured C/A code (0 on timeout)
- res_timeout_o  out  1  result is a timeout
- busy_o  out  1  state ≠ IDLE
- round_cnt_o  out  16  completed rounds, wraps 0xFFFF→0

## Operation
- States: IDLE, REQ, OUT.
- Edge detect:
  - valid_q <= codes_valid_i every cycle.
  - rise = codes_valid_i & ~valid_q.
- IDLE
  - start_o=0.
  - If enable_i=1, go to REQ and clear the timeout counter.
- REQ
  - start_o=1; the counter increments each cycle.
  - On rise: res_code_o<=ca_code_i, res_sv_o<=sv_num_o, res_timeout_o<=0; go to OUT.
  - Else if counter==TIMEOUT-1: res_code_o<=0, res_sv_o<=sv_num_o, res_timeout_o<=1; go to OUT.
  - rise wins over timeout in the same cycle.
- OUT
  - start_o=0, res_valid_o=1. res_* are held stable until res_valid_o & res_ready_i.
  - On that handshake:
    - round_cnt_o+=1.
    - sv_num_o advances by 1, wrapping SV_LAST→SV_FIRST.
    - Next state is REQ if enable_i=1 (counter cleared), else IDLE.
- enable_i deasserted in REQ or OUT does not abort: the round completes and the result is delivered, then the block goes to IDLE.
- enable_i is sampled only in IDLE and at the OUT handshake.
- Timeout counter width is $clog2(TIMEOUT); it never wraps within a round.
- Reset values, applied asynchronously and immediately (including mid-round):
  - state=IDLE, sv_num_o=SV_FIRST, start_o=0.
  - res_valid_o=0, res_sv_o=0, res_code_o=0, res_timeout_o=0.
  - busy_o=0, round_cnt_o=0, valid_q=0, counter=0.

## Timing
- IDLE with enable_i=1 at edge N: start_o=1 from edge N+1.
- rise sampled at edge M: res_valid_o=1 and start_o=0 from edge M+1, so capture latency is 1 cycle.
- Handshake at edge H: start_o=1 again from H+1 when enable_i=1.
  - start_o is therefore low for at least 1 cycle between rounds.
  - Back-to-back throughput is 2 cycles plus the generator latency per round.
- Timeout: start_o is high for exactly TIMEOUT cycles, then res_valid_o=1 on the next cycle.
- codes_valid_i already high on entry to REQ is not a rise; the block waits for a fresh 0→1 transition or the timeout.
- res_ready_i held low stalls indefinitely in OUT. start_o stays 0; no rounds are issued or lost.
- busy_o is combinational from state.

## Test plan
- Reset, then enable_i=1; the generator model raises codes_valid_i 5 cycles after start_o with ca_code_i=0x1ABC; res_ready_i=1.
  - Expected: res_sv_o=1, res_code_o=0x1ABC, res_timeout_o=0.
  - Expected: res_valid_o asserted 6 cycles after start_o rises; round_cnt_o=1.
- TIMEOUT=8, codes_valid_i tied 0.
  - Expected: start_o high 8 cycles, then res_timeout_o=1, res_code_o=0, res_sv_o=1.
  - Expected: the next round runs with sv_num_o=2.
- SV_FIRST=3, SV_LAST=5, continuous enable.
  - Expected: result sv sequence 3,4,5,3,4; round_cnt_o=5.
  - Expected: start_o low ≥1 cycle between rounds.
- res_ready_i=0 for 20 cycles in OUT, with codes_valid_i toggling.
  - Expected: res_* stable, start_o=0, no sv advance.
  - Expected: after ready, exactly one handshake and round_cnt_o+1.
- enable_i dropped mid-REQ.
  - Expected: the round completes, the result is delivered, then IDLE with busy_o=0 and sv_num_o advanced.
  - Separately, with codes_valid_i high before REQ entry: no capture until a fresh rise.
- wb_rst_ni pulsed low mid-OUT, asynchronously between edges.
  - Expected: res_valid_o, start_o and busy_o drop immediately; sv_num_o=SV_FIRST; round_cnt_o=0.

Source files
------------

// File: rtl/gps_round_sched_if.sv
// Generator and result-port signals of the GPS round scheduler.
// The scheduler side uses the master modport; generator/consumer models use slave.
interface gps_round_sched_if;
    logic        start_o;
    logic [5:0]  sv_num_o;
    logic        codes_valid_i;
    logic [12:0] ca_code_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [5:0]  res_sv_o;
    logic [12:0] res_code_o;
    logic        res_timeout_o;

    modport master (
        output start_o, sv_num_o, res_valid_o, res_sv_o, res_code_o, res_timeout_o,
        input  codes_valid_i, ca_code_i, res_ready_i
    );

    modport slave (
        input  start_o, sv_num_o, res_valid_o, res_sv_o, res_code_o, res_timeout_o,
        output codes_valid_i, ca_code_i, res_ready_i
    );
endinterface

// File: rtl/gps_round_sched.sv
// Round scheduler: scans sv_num over [SV_FIRST, SV_LAST], requests a code round,
// captures the C/A code on the code-valid rising edge (or times out) and hands it off.
module gps_round_sched #(
    parameter int SV_FIRST = 1,
    parameter int SV_LAST  = 32,
    parameter int TIMEOUT  = 4096
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  enable_i,
    gps_round_sched_if.master     rnd,
    output logic                  busy_o,
    output logic [15:0]           round_cnt_o
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic               valid_q_r;
    logic               rise_s;
    logic               cnt_done_s;
    logic               hs_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               start_r;
    logic [5:0]         sv_num_r;
    logic               res_valid_r;
    logic [5:0]         res_sv_r;
    logic [12:0]        res_code_r;
    logic               res_timeout_r;
    logic [15:0]        round_cnt_r;

    assign rise_s     = rnd.codes_valid_i & ~valid_q_r;
    assign cnt_done_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Next-state selection; rise takes priority over timeout in REQ.
    always_comb begin
        state_nx_s = state_r;
        hs_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_i) state_nx_s = ST_REQ;
                else          state_nx_s = ST_IDLE;
            end
            ST_REQ: begin
                if (rise_s)          state_nx_s = ST_OUT;
                else if (cnt_done_s) state_nx_s = ST_OUT;
                else                 state_nx_s = ST_REQ;
            end
            ST_OUT: begin
                if (rnd.res_ready_i) begin
                    hs_s       = 1'b1;
                    state_nx_s = enable_i ? ST_REQ : ST_IDLE;
                end else begin
                    state_nx_s = ST_OUT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, edge-detect history and the registered start/valid outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= ST_IDLE;
            valid_q_r   <= 1'b0;
            start_r     <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            valid_q_r   <= rnd.codes_valid_i;
            start_r     <= (state_nx_s == ST_REQ);
            res_valid_r <= (state_nx_s == ST_OUT);
        end
    end

    // Round timer restarts on every REQ entry and stops before it can wrap.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_r <= '0;
        end else if ((state_r == ST_REQ) && (state_nx_s == ST_REQ)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Result capture; the held values stay put for the whole OUT stall.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            res_sv_r      <= 6'd0;
            res_code_r    <= 13'd0;
            res_timeout_r <= 1'b0;
        end else if ((state_r == ST_REQ) && rise_s) begin
            res_sv_r      <= sv_num_r;
            res_code_r    <= rnd.ca_code_i;
            res_timeout_r <= 1'b0;
        end else if ((state_r == ST_REQ) && cnt_done_s) begin
            res_sv_r      <= sv_num_r;
            res_code_r    <= 13'd0;
            res_timeout_r <= 1'b1;
        end else begin
            res_sv_r      <= res_sv_r;
            res_code_r    <= res_code_r;
            res_timeout_r <= res_timeout_r;
        end
    end

    // Satellite stepping and round counting, both advanced only by the handshake.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sv_num_r    <= 6'(SV_FIRST);
            round_cnt_r <= 16'd0;
        end else if (hs_s) begin
            sv_num_r    <= (sv_num_r == 6'(SV_LAST)) ? 6'(SV_FIRST) : (sv_num_r + 6'd1);
            round_cnt_r <= round_cnt_r + 16'd1;
        end else begin
            sv_num_r    <= sv_num_r;
            round_cnt_r <= round_cnt_r;
        end
    end

    assign rnd.start_o       = start_r;
    assign rnd.sv_num_o      = sv_num_r;
    assign rnd.res_valid_o   = res_valid_r;
    assign rnd.res_sv_o      = res_sv_r;
    assign rnd.res_code_o    = res_code_r;
    assign rnd.res_timeout_o = res_timeout_r;
    assign busy_o            = (state_r != ST_IDLE);
    assign round_cnt_o       = round_cnt_r;

endmodule

// File: tb/tb_gps_round_sched.sv
// Directed-plus-random bench for gps_round_sched against a round-level reference model.
module tb_gps_round_sched;

    localparam int SV_FIRST = 3;
    localparam int SV_LAST  = 5;
    localparam int TIMEOUT  = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        enable_i;
    logic        busy_o;
    logic [15:0] round_cnt_o;

    gps_round_sched_if rnd ();

    gps_round_sched #(
        .SV_FIRST (SV_FIRST),
        .SV_LAST  (SV_LAST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .enable_i    (enable_i),
        .rnd         (rnd),
        .busy_o      (busy_o),
        .round_cnt_o (round_cnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_sv;
    int          exp_rounds;
    logic [12:0] exp_code;
    logic        exp_to;
    logic        cv_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cv(input logic v, input logic [12:0] c);
        rnd.codes_valid_i = v;
        rnd.ca_code_i     = c;
        cv_last           = v;
    endtask

    // mode 0: never valid, 1: rises at d, 2: random bits, 3: high on entry, drops, rises at d
    task automatic req_phase(input int mode, input int d_in);
        logic        cv [TIMEOUT];
        logic [12:0] ca [TIMEOUT];
        int d, rise_j, highs, n, exp_highs;
        logic prev;
        n = 0;
        while (rnd.start_o !== 1'b1 && n < 20) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("start_rise", 32'(rnd.start_o), 32'd1);
        check("sv_num_req", 32'(rnd.sv_num_o), 32'(exp_sv));
        d = (d_in >= 0) ? d_in : int'($urandom_range(0, TIMEOUT + 2));
        for (int j = 0; j < TIMEOUT; j++) begin
            case (mode)
                1:       cv[j] = (j >= d);
                2:       cv[j] = 1'($urandom_range(0, 1));
                3:       cv[j] = (j < 2) ? 1'b1 : (j >= d);
                default: cv[j] = 1'b0;
            endcase
            ca[j] = 13'($urandom);
        end
        rise_j = -1;
        prev   = cv_last;
        for (int j = 0; j < TIMEOUT; j++) begin
            if (rise_j < 0 && cv[j] && !prev) rise_j = j;
            prev = cv[j];
        end
        exp_highs = (rise_j >= 0) ? rise_j + 1 : TIMEOUT;
        exp_to    = (rise_j < 0);
        exp_code  = (rise_j >= 0) ? ca[rise_j] : 13'd0;
        highs = 0;
        while (rnd.start_o === 1'b1 && highs < TIMEOUT + 4) begin
            if (highs < TIMEOUT) drive_cv(cv[highs], ca[highs]);
            else                 drive_cv(1'b0, 13'd0);
            enable_i        = 1'($urandom_range(0, 1));
            rnd.res_ready_i = 1'($urandom_range(0, 1));
            highs++;
            @(negedge wb_clk_i);
        end
        check("start_high_cycles", 32'(highs), 32'(exp_highs));
        check("res_valid_set", 32'(rnd.res_valid_o), 32'd1);
        check("busy_in_out", 32'(busy_o), 32'd1);
        check("res_sv", 32'(rnd.res_sv_o), 32'(exp_sv));
        check("res_code", 32'(rnd.res_code_o), 32'(exp_code));
        check("res_timeout", 32'(rnd.res_timeout_o), 32'(exp_to));
    endtask

    task automatic out_phase(input int stall, input logic en_next);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            rnd.res_ready_i = 1'b0;
            drive_cv(1'($urandom_range(0, 1)), 13'($urandom));
            enable_i = 1'($urandom_range(0, 1));
            @(negedge wb_clk_i);
            if (rnd.res_valid_o !== 1'b1 || rnd.start_o !== 1'b0 ||
                rnd.res_sv_o !== 6'(exp_sv) || rnd.res_code_o !== exp_code ||
                rnd.res_timeout_o !== exp_to || rnd.sv_num_o !== 6'(exp_sv) ||
                round_cnt_o !== 16'(exp_rounds)) ok = 1'b0;
        end
        check("stall_hold", 32'(ok), 32'd1);
        rnd.res_ready_i = 1'b1;
        enable_i        = en_next;
        drive_cv(1'b0, 13'($urandom));
        @(negedge wb_clk_i);
        rnd.res_ready_i = 1'b0;
        exp_rounds = (exp_rounds + 1) % 65536;
        exp_sv     = (exp_sv == SV_LAST) ? SV_FIRST : exp_sv + 1;
        check("round_cnt", 32'(round_cnt_o), 32'(exp_rounds));
        check("sv_advance", 32'(rnd.sv_num_o), 32'(exp_sv));
        check("res_valid_clr", 32'(rnd.res_valid_o), 32'd0);
        check("start_after_hs", 32'(rnd.start_o), 32'(en_next));
        check("busy_after_hs", 32'(busy_o), 32'(en_next));
    endtask

    initial begin
        logic en_n;
        wb_rst_ni       = 1'b0;
        enable_i        = 1'b0;
        rnd.res_ready_i = 1'b0;
        drive_cv(1'b0, 13'd0);
        exp_sv     = SV_FIRST;
        exp_rounds = 0;
        repeat (3) @(negedge wb_clk_i);
        check("rst_start", 32'(rnd.start_o), 32'd0);
        check("rst_res_valid", 32'(rnd.res_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_sv_num", 32'(rnd.sv_num_o), 32'(SV_FIRST));
        check("rst_round_cnt", 32'(round_cnt_o), 32'd0);
        check("rst_res_sv", 32'(rnd.res_sv_o), 32'd0);
        check("rst_res_code", 32'(rnd.res_code_o), 32'd0);
        check("rst_res_to", 32'(rnd.res_timeout_o), 32'd0);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        check("idle_no_start", 32'(rnd.start_o), 32'd0);

        // capture five cycles after start, then a pure timeout round
        enable_i = 1'b1;
        req_phase(1, 5);
        out_phase(0, 1'b1);
        req_phase(0, -1);
        out_phase(0, 1'b1);

        // random rounds, random stalls, random enable drops
        for (int r = 0; r < 12; r++) begin
            en_n = 1'($urandom_range(0, 1));
            req_phase(1 + int'($urandom_range(0, 1)), -1);
            out_phase(int'($urandom_range(0, 3)), en_n);
            if (!en_n) begin
                repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
                check("idle_busy", 32'(busy_o), 32'd0);
                enable_i = 1'b1;
            end
        end

        // long consumer stall with code-valid toggling
        req_phase(2, -1);
        out_phase(20, 1'b1);

        // code-valid already high on REQ entry
        req_phase(1, -1);
        out_phase(0, 1'b0);
        drive_cv(1'b1, 13'h0123);
        repeat (2) @(negedge wb_clk_i);
        enable_i = 1'b1;
        req_phase(3, int'($urandom_range(3, TIMEOUT - 1)));
        out_phase(1, 1'b1);

        // asynchronous reset in the middle of OUT
        req_phase(1, -1);
        #2;
        wb_rst_ni = 1'b0;
        #1;
        check("arst_res_valid", 32'(rnd.res_valid_o), 32'd0);
        check("arst_start", 32'(rnd.start_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_sv_num", 32'(rnd.sv_num_o), 32'(SV_FIRST));
        check("arst_round_cnt", 32'(round_cnt_o), 32'd0);
        enable_i = 1'b0;
        drive_cv(1'b0, 13'd0);
        @(negedge wb_clk_i);
        wb_rst_ni  = 1'b1;
        exp_sv     = SV_FIRST;
        exp_rounds = 0;
        @(negedge wb_clk_i);
        enable_i = 1'b1;
        req_phase(1, -1);
        out_phase(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
